instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  ID stage, the consumer of the fetch stage's IF_ID word {pc[63:32], instr[31:0]}.
//  - Decodes the instruction and reads a 32x32 register file. Writes come back from WB.
//  - Keeps a busy scoreboard for RAW interlock and drives stall back to fetch.
//  - Registers the decoded fields into the ID/EX outputs.
// PARAMETERS
//  NREGS      32  register count (addr width fixed at 5)
//  CNT_W      32  width of the stats counters (DECODE_STATS_EN only)
// PORTS
//  clock        in   1   clock
//  reset        in   1   synchronous, active-low
//  if_id        in   64  {pc, instr} from fetch
//  if_valid     in   1   if_id holds a real instruction
//  flush        in   1   redirect from EX; squash instruction currently in ID
//  wb_en        in   1   register write from WB
//  wb_addr      in   5   write address
//  wb_data      in   32  write data
//  stall        out  1   combinational; fetch holds PC and IF_ID while high
//  id_valid     out  1   ID/EX outputs carry an issued instruction
//  id_pc        out  32  pc of issued instruction
//  id_opcode    out  6   instr[31:26]
//  id_rd        out  5   destination register
//  id_rs_val    out  32  rs operand
//  id_rt_val    out  32  rt operand
//  id_imm       out  32  extended immediate
//  id_alu_op    out  4   ALU_* code from package
//  id_reg_write out  1   instruction writes id_rd
//  id_branch    out  1   conditional branch (taken if rs==rt)
//  id_jump      out  1   unconditional relative jump
//  id_illegal   out  1   opcode not in table; issued as NOP, reg_write=0
// BEHAVIOUR
//  Reset (reset==0 at posedge): all outputs 0; all regfile entries 0; scoreboard 0.
//  Fields: rs=[25:21], rt=[20:16], rd=[15:11].
//  Opcode table:
//   000000 ADD, 000001 SUB, 000101 AND, 000110 OR, 000111 XOR, 001100 MUL
//    - reads rs,rt; writes rd
//   000011 SHL
//    - reads rs; writes rd; imm = zext(instr[5:0])
//   000010 LDI
//    - reads none; writes rd; imm = zext(instr[5:0])
//   001000 JMP
//    - reads none; imm = sext(instr[15:0])
//   001001 BEQ
//    - reads rs,rt; imm = sext(instr[15:0])
//  Latency: 1 cycle, if_id at edge N appears on id_* after edge N.
//  Regfile read is write-through: wb_en && wb_addr==src in the same cycle returns wb_data.
//  Scoreboard busy[32]:
//   - set busy[rd] when an instruction with reg_write issues.
//   - clear busy[wb_addr] on wb_en.
//   - set and clear of the same reg in the same cycle: set wins.
//  stall = if_valid && !flush && (any source read has busy[src] && !(wb_en && wb_addr==src)).
//  Issue = if_valid && !stall && !flush. On a non-issue cycle, id_valid=0 and the other
//   id_* fields hold their previous values.
//  flush: squashes the ID instruction (no issue, no scoreboard set) and overrides stall.
//   Same-cycle wb_en is still honoured.
//  Reset mid-stall: stall drops and the scoreboard clears; in-flight WB writes after reset
//   are still applied.
// CONFIGURATION
//  DECODE_STATS_EN defined:
//   - adds outputs n_issued, n_stalls, n_flushes [CNT_W-1:0].
//   - each counter increments once per cycle on its event, reset to 0, wraps at max.
//  Undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package id_pkg:
//   - OP_* opcode localparams and ALU_* codes.
//   - field-slice constants.
//   - IF_ID_W=64.
//  Sub-module id_regfile: 32x32, 2 read ports, 1 write port, write-through, sync clear.
//  Decode table, scoreboard and output register stay in the top module.
// TESTING
//  - ADD after WB preload: wb r2=5, r1=3, then ADD rs=2 rt=1 rd=0
//    -> id_rs_val=5, id_rt_val=3, id_rd=0, id_alu_op=ALU_ADD, id_reg_write=1.
//  - RAW stall: LDI rd=4 imm=7 issues, next SUB rs=4
//    -> stall=1, id_valid=0 until wb_en r4=7; same cycle stall=0 and id_rs_val=7.
//  - Write-through: WB r3=9 in the same cycle ID reads r3 -> id_rs_val=9, no stall.
//  - Branch decode: BEQ imm=16'hFFF9 -> id_imm=32'hFFFF_FFF9, id_branch=1, id_reg_write=0.
//  - Flush during stall: flush=1 -> stall=0, id_valid=0, busy unchanged.
//  - Illegal/reset: opcode 111111 -> id_illegal=1, id_reg_write=0.
//    reset=0 mid-stall -> next cycle all outputs 0 and stall=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU codes, field slices and the decode record.
package id_pkg;

    localparam int unsigned IF_ID_W = 64;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;

    localparam int unsigned PC_HI  = 63;
    localparam int unsigned PC_LO  = 32;
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_LDI = 6'b000010;
    localparam logic [5:0] OP_SHL = 6'b000011;
    localparam logic [5:0] OP_AND = 6'b000101;
    localparam logic [5:0] OP_OR  = 6'b000110;
    localparam logic [5:0] OP_XOR = 6'b000111;
    localparam logic [5:0] OP_JMP = 6'b001000;
    localparam logic [5:0] OP_BEQ = 6'b001001;
    localparam logic [5:0] OP_MUL = 6'b001100;

    // BEQ uses ALU_SUB so EX can test the zero result; LDI passes the immediate through.
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_MUL  = 4'd6,
        ALU_SHL  = 4'd7,
        ALU_PASS = 4'd8
    } alu_op_e;

    typedef struct packed {
        alu_op_e         alu_op;
        logic            reads_rs;
        logic            reads_rt;
        logic            reg_write;
        logic            branch;
        logic            jump;
        logic            illegal;
        logic [XLEN-1:0] imm;
    } dec_t;

endpackage

// File: rtl/id_regfile.sv
// 2-read/1-write register file with write-through reads and synchronous clear.
module id_regfile
    import id_pkg::*;
#(
    parameter int unsigned NREGS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [XLEN-1:0]   rdata_a,
    output logic [XLEN-1:0]   rdata_b,
    input  logic              wen,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_a = mem[raddr_a];
        rdata_b = mem[raddr_b];
        if (wen && waddr == raddr_a) rdata_a = wdata;
        if (wen && waddr == raddr_b) rdata_b = wdata;
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decode, register read, RAW busy scoreboard with stall, ID/EX register.
// Optional DECODE_STATS_EN adds issue/stall/flush counters.
module instruction_decode
    import id_pkg::*;
#(
    parameter int unsigned NREGS = 32
`ifdef DECODE_STATS_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [IF_ID_W-1:0] if_id,
    input  logic               if_valid,
    input  logic               flush,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               stall,
    output logic               id_valid,
    output logic [XLEN-1:0]    id_pc,
    output logic [5:0]         id_opcode,
    output logic [REG_AW-1:0]  id_rd,
    output logic [XLEN-1:0]    id_rs_val,
    output logic [XLEN-1:0]    id_rt_val,
    output logic [XLEN-1:0]    id_imm,
    output logic [3:0]         id_alu_op,
    output logic               id_reg_write,
    output logic               id_branch,
    output logic               id_jump,
    output logic               id_illegal
`ifdef DECODE_STATS_EN
    ,
    output logic [CNT_W-1:0]   n_issued,
    output logic [CNT_W-1:0]   n_stalls,
    output logic [CNT_W-1:0]   n_flushes
`endif
);

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instr;
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    dec_t              dec;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [NREGS-1:0]  busy;
    logic              haz_rs;
    logic              haz_rt;
    logic              issue;

    assign pc     = if_id[PC_HI:PC_LO];
    assign instr  = if_id[XLEN-1:0];
    assign opcode = instr[OPC_HI:OPC_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign rd     = instr[RD_HI:RD_LO];

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: begin
                dec.reads_rs  = 1'b1;
                dec.reads_rt  = 1'b1;
                dec.reg_write = 1'b1;
                case (opcode)
                    OP_ADD:  dec.alu_op = ALU_ADD;
                    OP_SUB:  dec.alu_op = ALU_SUB;
                    OP_AND:  dec.alu_op = ALU_AND;
                    OP_OR:   dec.alu_op = ALU_OR;
                    OP_XOR:  dec.alu_op = ALU_XOR;
                    default: dec.alu_op = ALU_MUL;
                endcase
            end
            OP_SHL: begin
                dec.alu_op    = ALU_SHL;
                dec.reads_rs  = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm       = {26'd0, instr[5:0]};
            end
            OP_LDI: begin
                dec.alu_op    = ALU_PASS;
                dec.reg_write = 1'b1;
                dec.imm       = {26'd0, instr[5:0]};
            end
            OP_JMP: begin
                dec.jump = 1'b1;
                dec.imm  = {{16{instr[15]}}, instr[15:0]};
            end
            OP_BEQ: begin
                dec.alu_op   = ALU_SUB;
                dec.reads_rs = 1'b1;
                dec.reads_rt = 1'b1;
                dec.branch   = 1'b1;
                dec.imm      = {{16{instr[15]}}, instr[15:0]};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    id_regfile #(.NREGS(NREGS)) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val),
        .wen     (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // A same-cycle WB to a busy source is forwarded by the regfile, so it is not a hazard.
    assign haz_rs = dec.reads_rs && busy[rs] && !(wb_en && wb_addr == rs);
    assign haz_rt = dec.reads_rt && busy[rt] && !(wb_en && wb_addr == rt);
    assign stall  = if_valid && !flush && (haz_rs || haz_rt);
    assign issue  = if_valid && !stall && !flush;

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            logic [NREGS-1:0] nxt;
            nxt = busy;
            if (wb_en) nxt[wb_addr] = 1'b0;
            if (issue && dec.reg_write) nxt[rd] = 1'b1;
            busy <= nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_opcode    <= '0;
            id_rd        <= '0;
            id_rs_val    <= '0;
            id_rt_val    <= '0;
            id_imm       <= '0;
            id_alu_op    <= '0;
            id_reg_write <= 1'b0;
            id_branch    <= 1'b0;
            id_jump      <= 1'b0;
            id_illegal   <= 1'b0;
        end else begin
            id_valid <= issue;
            if (issue) begin
                id_pc        <= pc;
                id_opcode    <= opcode;
                id_rd        <= rd;
                id_rs_val    <= rs_val;
                id_rt_val    <= rt_val;
                id_imm       <= dec.imm;
                id_alu_op    <= dec.alu_op;
                id_reg_write <= dec.reg_write;
                id_branch    <= dec.branch;
                id_jump      <= dec.jump;
                id_illegal   <= dec.illegal;
            end
        end
    end

`ifdef DECODE_STATS_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            n_issued  <= '0;
            n_stalls  <= '0;
            n_flushes <= '0;
        end else begin
            if (issue) n_issued  <= n_issued + 1'b1;
            if (stall) n_stalls  <= n_stalls + 1'b1;
            if (flush) n_flushes <= n_flushes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: expected ID/EX records queued at drive time, popped on issue.
module tb_instruction_decode;
    import id_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } out_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] if_id = '0;
    logic        if_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_reg_write;
    logic        id_branch;
    logic        id_jump;
    logic        id_illegal;
`ifdef DECODE_STATS_EN
    logic [31:0] n_issued, n_stalls, n_flushes;
`endif

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    out_t exp_v;
    out_t last_v;
    out_t obs;

    instruction_decode dut (
        .clock(clock), .reset(reset), .if_id(if_id), .if_valid(if_valid), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
        .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_branch(id_branch), .id_jump(id_jump),
        .id_illegal(id_illegal)
`ifdef DECODE_STATS_EN
        , .n_issued(n_issued), .n_stalls(n_stalls), .n_flushes(n_flushes)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] low);
        return {op, rs, rt, low};
    endfunction

    function automatic out_t mk(logic [31:0] pc, logic [5:0] op, logic [4:0] rd, logic [31:0] rsv,
                                logic [31:0] rtv, logic [31:0] imm, alu_op_e alu,
                                logic rw, logic br, logic jp, logic il);
        out_t r;
        r = '{1'b1, pc, op, rd, rsv, rtv, imm, alu, rw, br, jp, il};
        return r;
    endfunction

    function automatic out_t observe();
        out_t r;
        r = '{id_valid, id_pc, id_opcode, id_rd, id_rs_val, id_rt_val, id_imm, id_alu_op,
              id_reg_write, id_branch, id_jump, id_illegal};
        return r;
    endfunction

    task automatic drive(logic v, logic [31:0] pc, logic [31:0] ins, logic fl,
                         logic we, logic [4:0] wa, logic [31:0] wd);
        if_valid = v;
        if_id    = {pc, ins};
        flush    = fl;
        wb_en    = we;
        wb_addr  = wa;
        wb_data  = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        obs = observe();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", obs); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        reset = 1'b1;
    endtask

    task automatic test_add();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd5);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd3);
        tick();
        drive(1'b1, 32'h100, enc(OP_ADD, 5'd2, 5'd1, 16'h0000), 1'b0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back(mk(32'h100, OP_ADD, 5'd0, 32'd5, 32'd3, 32'd0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        last_v = exp_v;
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL add_issue got %h want %h", obs, exp_v); end
        // idle cycle: valid drops, fields hold; WB r0 clears its busy bit
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'd0);
        tick();
        obs = observe();
        last_v.valid = 1'b0;
        checks++;
        if (obs !== last_v) begin errors++; $display("FAIL idle_hold got %h want %h", obs, last_v); end
    endtask

    task automatic test_raw_stall();
        drive(1'b1, 32'h104, enc(OP_LDI, 5'd0, 5'd0, {5'd4, 5'd0, 6'd7}), 1'b0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back(mk(32'h104, OP_LDI, 5'd4, 32'd0, 32'd0, 32'd7, ALU_PASS, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL ldi_issue got %h want %h", obs, exp_v); end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'h108, enc(OP_SUB, 5'd4, 5'd0, {5'd5, 11'd0}), 1'b0, 1'b0, 5'd0, 32'd0);
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall cyc=%0d got %b want 1", c, stall); end
            tick();
            checks++;
            if (id_valid !== 1'b0) begin errors++; $display("FAIL raw_no_issue cyc=%0d got %b want 0", c, id_valid); end
        end
        drive(1'b1, 32'h108, enc(OP_SUB, 5'd4, 5'd0, {5'd5, 11'd0}), 1'b0, 1'b1, 5'd4, 32'd7);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL raw_release got %b want 0", stall); end
        exp_q.push_back(mk(32'h108, OP_SUB, 5'd5, 32'd7, 32'd0, 32'd0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL raw_issue got %h want %h", obs, exp_v); end
    endtask

    task automatic test_write_through();
        drive(1'b1, 32'h10C, enc(OP_LDI, 5'd0, 5'd0, {5'd3, 5'd0, 6'd2}), 1'b0, 1'b1, 5'd5, 32'd11);
        exp_q.push_back(mk(32'h10C, OP_LDI, 5'd3, 32'd0, 32'd0, 32'd2, ALU_PASS, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wt_ldi got %h want %h", obs, exp_v); end
        drive(1'b1, 32'h110, enc(OP_OR, 5'd3, 5'd3, {5'd6, 11'd0}), 1'b0, 1'b1, 5'd3, 32'd9);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL wt_stall got %b want 0", stall); end
        exp_q.push_back(mk(32'h110, OP_OR, 5'd6, 32'd9, 32'd9, 32'd0, ALU_OR, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL wt_issue got %h want %h", obs, exp_v); end
    endtask

    task automatic test_branch_jump();
        drive(1'b1, 32'h114, enc(OP_BEQ, 5'd5, 5'd6, 16'hFFF9), 1'b0, 1'b1, 5'd6, 32'd20);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL beq_stall got %b want 0", stall); end
        exp_q.push_back(mk(32'h114, OP_BEQ, 5'd31, 32'd11, 32'd20, 32'hFFFF_FFF9, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 32'h114, enc(OP_BEQ, 5'd5, 5'd6, 16'hFFF9), 1'b0, 1'b1, 5'd6, 32'd20);
        tick();
        drive(1'b1, 32'h118, enc(OP_JMP, 5'd0, 5'd0, 16'h8000), 1'b0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back(mk(32'h118, OP_JMP, 5'd16, 32'd0, 32'd0, 32'hFFFF_8000, ALU_NOP, 1'b0, 1'b0, 1'b1, 1'b0));
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL beq_issue got %h want %h", obs, exp_v); end
        tick();
        drive(1'b1, 32'h11C, enc(OP_SHL, 5'd5, 5'd0, {5'd7, 5'd0, 6'd3}), 1'b0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back(mk(32'h11C, OP_SHL, 5'd7, 32'd11, 32'd0, 32'd3, ALU_SHL, 1'b1, 1'b0, 1'b0, 1'b0));
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL jmp_issue got %h want %h", obs, exp_v); end
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL shl_issue got %h want %h", obs, exp_v); end
    endtask

    task automatic test_flush();
        logic [31:0] sub_i;
        sub_i = enc(OP_SUB, 5'd8, 5'd0, {5'd9, 11'd0});
        drive(1'b1, 32'h120, enc(OP_LDI, 5'd0, 5'd0, {5'd8, 5'd0, 6'd1}), 1'b0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back(mk(32'h120, OP_LDI, 5'd8, 32'd0, 32'd0, 32'd1, ALU_PASS, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fl_ldi got %h want %h", obs, exp_v); end
        drive(1'b1, 32'h124, sub_i, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fl_pre_stall got %b want 1", stall); end
        tick();
        drive(1'b1, 32'h124, sub_i, 1'b1, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fl_override got %b want 0", stall); end
        tick();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_squash got %b want 0", id_valid); end
        drive(1'b1, 32'h124, sub_i, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL fl_busy_kept got %b want 1", stall); end
        tick();
        drive(1'b1, 32'h124, sub_i, 1'b1, 1'b1, 5'd8, 32'd4);
        tick();
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_wb_squash got %b want 0", id_valid); end
        drive(1'b1, 32'h124, sub_i, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fl_wb_honoured got %b want 0", stall); end
        exp_q.push_back(mk(32'h124, OP_SUB, 5'd9, 32'd4, 32'd0, 32'd0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fl_sub_issue got %h want %h", obs, exp_v); end
        drive(1'b1, 32'h128, enc(OP_LDI, 5'd0, 5'd0, {5'd10, 5'd0, 6'd3}), 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 32'h12C, enc(OP_AND, 5'd10, 5'd0, {5'd11, 11'd0}), 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL fl_no_set got %b want 0", stall); end
        exp_q.push_back(mk(32'h12C, OP_AND, 5'd11, 32'd0, 32'd0, 32'd0, ALU_AND, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL fl_and_issue got %h want %h", obs, exp_v); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 32'h130, enc(6'b111111, 5'd0, 5'd0, {5'd12, 11'd0}), 1'b0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back(mk(32'h130, 6'b111111, 5'd12, 32'd0, 32'd0, 32'd0, ALU_NOP, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL illegal_issue got %h want %h", obs, exp_v); end
        drive(1'b1, 32'h134, enc(OP_ADD, 5'd12, 5'd0, {5'd13, 11'd0}), 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL illegal_no_busy got %b want 0", stall); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] sub_i;
        sub_i = enc(OP_SUB, 5'd14, 5'd5, {5'd15, 11'd0});
        drive(1'b1, 32'h138, enc(OP_LDI, 5'd0, 5'd0, {5'd14, 5'd0, 6'd5}), 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 32'h13C, sub_i, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b want 1", stall); end
        reset = 1'b0;
        tick();
        obs = observe();
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", obs); end
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b want 0", stall); end
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd14, 32'd33);
        tick();
        drive(1'b1, 32'h13C, sub_i, 1'b0, 1'b0, 5'd0, 32'd0);
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rst_post_stall got %b want 0", stall); end
        exp_q.push_back(mk(32'h13C, OP_SUB, 5'd15, 32'd33, 32'd0, 32'd0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL rst_post_issue got %h want %h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h140, enc(OP_XOR, 5'd2, 5'd3, {5'd4, 11'd0}), 1'b0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back(mk(32'h140, OP_XOR, 5'd4, 32'd0, 32'd0, 32'd0, ALU_XOR, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        drive(1'b1, 32'h144, enc(OP_MUL, 5'd15, 5'd2, {5'd16, 11'd0}), 1'b0, 1'b1, 5'd15, 32'd6);
        exp_q.push_back(mk(32'h144, OP_MUL, 5'd16, 32'd6, 32'd0, 32'd0, ALU_MUL, 1'b1, 1'b0, 1'b0, 1'b0));
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL b2b_first got %h want %h", obs, exp_v); end
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0);
        obs = observe();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL b2b_second got %h want %h", obs, exp_v); end
        tick();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_raw_stall();
        test_write_through();
        test_branch_jump();
        test_flush();
        test_illegal();
        test_reset_mid_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
